// File: rtl/unified_mem_responder_pkg.sv
// Shared definitions for the unified memory responder: RV32 width codes,
// FSM state encoding, arbiter grant identifiers and the access-size helper.
package unified_mem_responder_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SERVE  = 2'd1,
        ST_SPLIT2 = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    // Byte lanes touched by an access at offset 0; reserved codes fall back to a word.
    function automatic logic [3:0] f3_size_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/unified_mem_responder_ls_align.sv
// Combinational load/store lane steering: per-beat byte enables and shifted
// store data, plus merge and sign/zero extension of load bytes.
module unified_mem_responder_ls_align
    import unified_mem_responder_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic        i_beat2,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_lo_word,
    input  logic [31:0] i_hi_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_split,
    output logic [31:0] o_load
);

    logic [7:0]  w_mask8;
    logic [4:0]  w_shamt;
    logic [63:0] w_wsh;
    logic [31:0] w_rsh;

    // Lanes 7..4 of the two-word window belong to the following word.
    assign w_shamt = {i_off, 3'b000};
    assign w_mask8 = {4'b0000, f3_size_mask(i_funct3)} << i_off;
    assign w_wsh   = {32'h0, i_wdata} << w_shamt;
    assign w_rsh   = 32'({i_hi_word, i_lo_word} >> w_shamt);

    assign o_split = |w_mask8[7:4];
    assign o_be    = i_beat2 ? w_mask8[7:4] : w_mask8[3:0];
    assign o_wdata = i_beat2 ? w_wsh[63:32] : w_wsh[31:0];

    always_comb begin
        o_load = w_rsh;
        case (i_funct3)
            F3_LB:   o_load = {{24{w_rsh[7]}}, w_rsh[7:0]};
            F3_LH:   o_load = {{16{w_rsh[15]}}, w_rsh[15:0]};
            F3_LBU:  o_load = {24'h0, w_rsh[7:0]};
            F3_LHU:  o_load = {16'h0, w_rsh[15:0]};
            default: o_load = w_rsh;
        endcase
    end

endmodule

// File: rtl/unified_mem_responder.sv
// Single-ported byte-addressed RAM shared by instruction fetch and load/store,
// with round-robin arbitration and two-beat handling of word-crossing accesses.
module unified_mem_responder
    import unified_mem_responder_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_valid,
    output logic              busy
);

    localparam int WORD_W = ADDR_W - 2;
    localparam int DEPTH  = 1 << WORD_W;

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_lo;
    state_t      r_state;
    grant_t      r_last;
    logic [31:0] r_i_rdata;
    logic        r_i_valid;
    logic [31:0] r_d_rdata;
    logic        r_d_valid;
    logic        r_busy;

    logic              w_can_grant;
    logic              w_i_pend;
    logic              w_d_pend;
    logic              w_gnt_i;
    logic              w_gnt_d;
    logic              w_beat2;
    logic [WORD_W-1:0] w_d_word;
    logic [WORD_W-1:0] w_ram_addr;
    logic [31:0]       w_ram_q;
    logic              w_wr_en;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata_sh;
    logic              w_split;
    logic [31:0]       w_load;
    logic              w_unused_ok;

    // A port whose response is visible this cycle still holds its old request, so mask it.
    assign w_can_grant = (r_state != ST_SPLIT2);
    assign w_i_pend    = i_req & ~r_i_valid;
    assign w_d_pend    = d_req & ~r_d_valid;
    assign w_gnt_d     = w_can_grant & w_d_pend & (~w_i_pend | (r_last == GRANT_FETCH));
    assign w_gnt_i     = w_can_grant & w_i_pend & ~w_gnt_d;

    assign w_beat2     = (r_state == ST_SPLIT2);
    assign w_d_word    = d_addr[ADDR_W-1:2];
    assign w_ram_addr  = w_beat2 ? (w_d_word + WORD_W'(1))
                       : (w_gnt_i ? i_addr[ADDR_W-1:2] : w_d_word);
    assign w_ram_q     = r_mem[w_ram_addr];
    assign w_wr_en     = d_we & (w_gnt_d | w_beat2);
    assign w_unused_ok = ^i_addr[1:0];

    unified_mem_responder_ls_align u_align (
        .i_funct3  (d_funct3),
        .i_off     (d_addr[1:0]),
        .i_beat2   (w_beat2),
        .i_wdata   (d_wdata),
        .i_lo_word (w_beat2 ? r_lo : w_ram_q),
        .i_hi_word (w_ram_q),
        .o_be      (w_be),
        .o_wdata   (w_wdata_sh),
        .o_split   (w_split),
        .o_load    (w_load)
    );

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_ram_addr][8*b +: 8] <= w_wdata_sh[8*b +: 8];
            end
        end
    end

    // First-beat word of a split load, merged with the second beat next cycle.
    always_ff @(posedge clk) begin
        if (w_gnt_d) r_lo <= w_ram_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_last    <= GRANT_FETCH;
            r_i_rdata <= 32'h0;
            r_i_valid <= 1'b0;
            r_d_rdata <= 32'h0;
            r_d_valid <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_i_valid <= 1'b0;
            r_d_valid <= 1'b0;
            r_busy    <= 1'b0;
            if (w_beat2) begin
                r_d_valid <= 1'b1;
                r_d_rdata <= d_we ? 32'h0 : w_load;
                r_state   <= ST_SERVE;
            end else if (w_gnt_d) begin
                r_last <= GRANT_DATA;
                if (w_split) begin
                    r_busy  <= 1'b1;
                    r_state <= ST_SPLIT2;
                end else begin
                    r_d_valid <= 1'b1;
                    r_d_rdata <= d_we ? 32'h0 : w_load;
                    r_state   <= ST_SERVE;
                end
            end else if (w_gnt_i) begin
                r_last    <= GRANT_FETCH;
                r_i_valid <= 1'b1;
                r_i_rdata <= w_ram_q;
                r_state   <= ST_SERVE;
            end else begin
                r_state <= ST_IDLE;
            end
        end
    end

    assign i_rdata = r_i_rdata;
    assign i_valid = r_i_valid;
    assign d_rdata = r_d_rdata;
    assign d_valid = r_d_valid;
    assign busy    = r_busy;

endmodule

// File: tb/tb_unified_mem_responder.sv
// Directed bench for unified_mem_responder: table of load/store vectors plus
// hand sequences for arbitration, store/fetch ordering and reset mid-split.
module tb_unified_mem_responder;

    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_rdata;
    logic              i_valid;
    logic              d_req;
    logic              d_we;
    logic [2:0]        d_funct3;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              d_valid;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;

    unified_mem_responder #(.ADDR_W(ADDR_W), .INIT_FILE("")) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_valid  (i_valid),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_funct3 (d_funct3),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_valid  (d_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [8:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vt [25];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic data_op(input logic we, input logic [2:0] f3, input logic [8:0] a,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output int lat, output logic saw_busy);
        d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd; d_req = 1'b1;
        lat = 0; saw_busy = 1'b0; rd = 32'hxxxxxxxx;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (busy) saw_busy = 1'b1;
            if (d_valid) begin
                lat = c;
                rd  = d_rdata;
                break;
            end
        end
        d_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic fetch_op(input logic [8:0] a, output logic [31:0] rd, output int lat);
        i_addr = a; i_req = 1'b1; lat = 0; rd = 32'hxxxxxxxx;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (i_valid) begin
                lat = c;
                rd  = i_rdata;
                break;
            end
        end
        i_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        logic        sb;
        logic        seq [8];
        int          nd, ni, k;
        logic [31:0] fetched;
        int          d_at, i_at;

        vt[0]  = '{1'b1, 3'b010, 9'h000, 32'h00500093, 32'h00000000, 1};
        vt[1]  = '{1'b1, 3'b010, 9'h010, 32'h11223344, 32'h00000000, 1};
        vt[2]  = '{1'b1, 3'b000, 9'h011, 32'h00000080, 32'h00000000, 1};
        vt[3]  = '{1'b0, 3'b000, 9'h011, 32'h0,        32'hFFFFFF80, 1};
        vt[4]  = '{1'b0, 3'b100, 9'h011, 32'h0,        32'h00000080, 1};
        vt[5]  = '{1'b0, 3'b010, 9'h010, 32'h0,        32'h11228044, 1};
        vt[6]  = '{1'b1, 3'b000, 9'h012, 32'hFFFFFF55, 32'h00000000, 1};
        vt[7]  = '{1'b0, 3'b010, 9'h010, 32'h0,        32'h11558044, 1};
        vt[8]  = '{1'b1, 3'b010, 9'h006, 32'hAABBCCDD, 32'h00000000, 2};
        vt[9]  = '{1'b0, 3'b010, 9'h006, 32'h0,        32'hAABBCCDD, 2};
        vt[10] = '{1'b0, 3'b001, 9'h007, 32'h0,        32'hFFFFBBCC, 2};
        vt[11] = '{1'b0, 3'b101, 9'h007, 32'h0,        32'h0000BBCC, 2};
        vt[12] = '{1'b0, 3'b001, 9'h008, 32'h0,        32'hFFFFAABB, 1};
        vt[13] = '{1'b1, 3'b001, 9'h1FF, 32'h00001234, 32'h00000000, 2};
        vt[14] = '{1'b0, 3'b101, 9'h1FF, 32'h0,        32'h00001234, 2};
        vt[15] = '{1'b0, 3'b010, 9'h000, 32'h0,        32'h00500012, 1};
        vt[16] = '{1'b0, 3'b100, 9'h013, 32'h0,        32'h00000011, 1};
        vt[17] = '{1'b0, 3'b001, 9'h012, 32'h0,        32'h00001155, 1};
        vt[18] = '{1'b0, 3'b011, 9'h010, 32'h0,        32'h11558044, 1};
        vt[19] = '{1'b1, 3'b111, 9'h00C, 32'hDEADBEEF, 32'h00000000, 1};
        vt[20] = '{1'b0, 3'b010, 9'h00C, 32'h0,        32'hDEADBEEF, 1};
        vt[21] = '{1'b0, 3'b000, 9'h00F, 32'h0,        32'hFFFFFFDE, 1};
        vt[22] = '{1'b0, 3'b001, 9'h002, 32'h0,        32'h00000050, 1};
        vt[23] = '{1'b0, 3'b010, 9'h00D, 32'h0,        32'h44DEADBE, 2};
        vt[24] = '{1'b0, 3'b000, 9'h1FF, 32'h0,        32'h00000034, 1};

        reset = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_funct3 = 3'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check32("reset_i_valid", {31'h0, i_valid}, 32'h0);
        check32("reset_d_valid", {31'h0, d_valid}, 32'h0);
        check32("reset_busy",    {31'h0, busy},    32'h0);
        check32("reset_i_rdata", i_rdata, 32'h0);
        check32("reset_d_rdata", d_rdata, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 25; v++) begin
            data_op(vt[v].we, vt[v].f3, vt[v].addr, vt[v].wd, rd, lat, sb);
            check32($sformatf("vec%0d_rdata", v), rd, vt[v].exp);
            check32($sformatf("vec%0d_latency", v), lat, vt[v].lat);
            check32($sformatf("vec%0d_busy", v), {31'h0, sb}, {31'h0, vt[v].lat == 2});
        end

        fetch_op(9'h003, rd, lat);
        check32("fetch_w0_data", rd, 32'h00500012);
        check32("fetch_w0_latency", lat, 1);
        fetch_op(9'h010, rd, lat);
        check32("fetch_w4_data", rd, 32'h11558044);

        // Both ports held: last grant was fetch, so data goes first, then alternate.
        i_addr = 9'h010; i_req = 1'b1;
        d_we = 1'b0; d_funct3 = 3'b010; d_addr = 9'h000; d_req = 1'b1;
        nd = 0; ni = 0; k = 0;
        for (int c = 0; c < 20 && k < 8; c++) begin
            @(posedge clk); #1;
            if (d_valid && i_valid) begin
                n_cmp++; n_bad++;
                $display("FAIL rr_both_valid: got both valid, expected one");
            end
            if (d_valid) begin
                seq[k] = 1'b1; k++; nd++;
                check32("rr_d_data", d_rdata, 32'h00500012);
                if (nd == 4) d_req = 1'b0;
            end else if (i_valid) begin
                seq[k] = 1'b0; k++; ni++;
                check32("rr_i_data", i_rdata, 32'h11558044);
                if (ni == 4) i_req = 1'b0;
            end
        end
        d_req = 1'b0; i_req = 1'b0;
        check32("rr_count", k, 8);
        for (int j = 0; j < 8; j++) begin
            if (j < k) check32($sformatf("rr_order%0d", j), {31'h0, seq[j]}, {31'h0, (j % 2) == 0});
        end
        @(posedge clk); #1;

        // Store and fetch to the same word together: store wins, fetch sees new data.
        d_we = 1'b1; d_funct3 = 3'b010; d_addr = 9'h020; d_wdata = 32'hCAFEF00D; d_req = 1'b1;
        i_addr = 9'h020; i_req = 1'b1;
        d_at = 0; i_at = 0; fetched = 32'h0;
        for (int c = 1; c <= 10 && (d_at == 0 || i_at == 0); c++) begin
            @(posedge clk); #1;
            if (d_valid) begin d_at = c; d_req = 1'b0; end
            if (i_valid) begin i_at = c; fetched = i_rdata; i_req = 1'b0; end
        end
        check32("sf_d_cycle", d_at, 1);
        check32("sf_i_cycle", i_at, 2);
        check32("sf_fetch_data", fetched, 32'hCAFEF00D);
        @(posedge clk); #1;

        // Reset during the second beat of a split store.
        data_op(1'b1, 3'b010, 9'h000, 32'h01020304, rd, lat, sb);
        data_op(1'b1, 3'b010, 9'h004, 32'h05060708, rd, lat, sb);
        d_we = 1'b1; d_funct3 = 3'b010; d_addr = 9'h002; d_wdata = 32'hA1B2C3D4; d_req = 1'b1;
        @(posedge clk); #1;
        check32("rst_split_busy", {31'h0, busy}, 32'h1);
        reset = 1'b0; d_req = 1'b0;
        #1;
        check32("rst_busy_cleared", {31'h0, busy}, 32'h0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check32("rst_no_d_valid", {31'h0, d_valid}, 32'h0);
        end
        check32("rst_i_rdata", i_rdata, 32'h0);
        check32("rst_d_rdata", d_rdata, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        check32("rst_no_late_valid", {31'h0, d_valid}, 32'h0);
        data_op(1'b0, 3'b010, 9'h000, 32'h0, rd, lat, sb);
        check32("rst_first_beat_written", rd, 32'hC3D40304);
        data_op(1'b0, 3'b010, 9'h004, 32'h0, rd, lat, sb);
        check32("rst_second_beat_kept", rd, 32'h05060708);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
